rsa_operand_serializer: RTL and testbench

- Parametrised successor to the fixed 512-bit/32-bit parallel-to-sequential operand converter that feeds the RSA core's Kin/Min/Din word inputs.
- Loads one wide operand and streams it out as WORD_W-bit words under a valid/ready handshake.
- Word count is selectable at run time, so CRT half-length operands stream without a separate instance.
- Word order is selectable (LSW-first or MSW-first); a done pulse marks the end of each stream.

---
 rtl/ser_pkg.sv | 19 +
 rtl/ser_align.sv | 30 +++
 rtl/rsa_operand_serializer.sv | 103 ++++++++++
 tb/tb_rsa_operand_serializer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and length helpers for the RSA operand serializer
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    function automatic int unsigned nwords(input int unsigned op_w, input int unsigned word_w);
        return op_w / word_w;
    endfunction

    // Zero or an over-long request means "the whole operand".
    function automatic int unsigned eff_len(input int unsigned len_words, input int unsigned n);
        return ((len_words == 0) || (len_words > n)) ? n : len_words;
    endfunction

endpackage

// File: rtl/ser_align.sv
// rtl/ser_align.sv - combinational pre-alignment of the operand before it enters the shift register
module ser_align
    import ser_pkg::*;
#(
    parameter int OP_W   = 512,
    parameter int WORD_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic [OP_W-1:0]  data_in,
    input  logic [LEN_W-1:0] len,
    input  logic             msw_first,
    output logic [OP_W-1:0]  aligned
);

    localparam int NW = nwords(OP_W, WORD_W);

    logic [OP_W-1:0] keep_mask;

    // MSW-first pushes word len-1 to the top, dropping the unused upper words;
    // LSW-first masks the unused upper words so they never sit in the shifter.
    always_comb begin
        keep_mask = ~({OP_W{1'b1}} << (32'(len) * WORD_W));
        if (msw_first) begin
            aligned = data_in << ((NW - 32'(len)) * WORD_W);
        end else begin
            aligned = data_in & keep_mask;
        end
    end

endmodule

// File: rtl/rsa_operand_serializer.sv
// rtl/rsa_operand_serializer.sv - wide operand to word stream converter; SER_PARITY_EN adds out_par
module rsa_operand_serializer
    import ser_pkg::*;
#(
    parameter int OP_W   = 512,
    parameter int WORD_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [OP_W-1:0]   data_in,
    input  logic [LEN_W-1:0]  len_words,
    input  logic              msw_first,
    output logic [WORD_W-1:0] out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              busy,
    output logic              done
`ifdef SER_PARITY_EN
    ,
    output logic              out_par
`endif
);

    localparam int NW = nwords(OP_W, WORD_W);

    ser_state_t        state;
    ser_state_t        state_nxt;
    logic [OP_W-1:0]   sr;
    logic [OP_W-1:0]   aligned;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  l_eff;
    logic              msw_q;

    assign l_eff = LEN_W'(eff_len(32'(len_words), NW));

    ser_align #(
        .OP_W   (OP_W),
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_align (
        .data_in   (data_in),
        .len       (l_eff),
        .msw_first (msw_first),
        .aligned   (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld) state_nxt = SHIFT;
            SHIFT:   if (out_rdy && (cnt == LEN_W'(1))) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            msw_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld) begin
                        sr    <= aligned;
                        cnt   <= l_eff;
                        msw_q <= msw_first;
                    end
                end
                SHIFT: begin
                    if (out_rdy) begin
                        sr  <= msw_q ? (sr << WORD_W) : (sr >> WORD_W);
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                DONE:    sr <= '0;
                default: sr <= '0;
            endcase
        end
    end

    // Outputs decode straight from registered state, so reset clears them at once.
    assign out_vld  = (state == SHIFT);
    assign out_data = out_vld ? (msw_q ? sr[OP_W-1 -: WORD_W] : sr[WORD_W-1:0]) : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

`ifdef SER_PARITY_EN
    assign out_par = ^out_data;
`endif

endmodule

// File: tb/tb_rsa_operand_serializer.sv
// tb/tb_rsa_operand_serializer.sv - directed bench with word-queue model for rsa_operand_serializer
module tb_rsa_operand_serializer;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b0;
    logic [63:0] data_in = '0;
    logic [2:0]  len_words = '0;
    logic        msw_first = 1'b0;
    logic [15:0] out_data;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic        busy;
    logic        done;
`ifdef SER_PARITY_EN
    logic        out_par;
    logic        out_par_w;
`endif

    logic         ld_w = 1'b0;
    logic [511:0] data_w = '0;
    logic [4:0]   len_w = '0;
    logic         msw_w = 1'b0;
    logic [31:0]  out_data_w;
    logic         out_vld_w;
    logic         busy_w;
    logic         done_w;

    always #5 clk = ~clk;

    rsa_operand_serializer #(.OP_W(64), .WORD_W(16), .LEN_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .data_in   (data_in),
        .len_words (len_words),
        .msw_first (msw_first),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .busy      (busy),
        .done      (done)
`ifdef SER_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    rsa_operand_serializer #(.OP_W(512), .WORD_W(32), .LEN_W(5)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld_w),
        .data_in   (data_w),
        .len_words (len_w),
        .msw_first (msw_w),
        .out_data  (out_data_w),
        .out_vld   (out_vld_w),
        .out_rdy   (1'b1),
        .busy      (busy_w),
        .done      (done_w)
`ifdef SER_PARITY_EN
        ,
        .out_par   (out_par_w)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: the words a stream must emit, in order, plus a pending done pulse.
    logic [15:0] exp_q[$];
    bit          done_due = 0;
    int          ld_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic [15:0] acc_w[$];
    int          acc_c[$];
    bit          ev, eb;
    logic [15:0] ed;
    int          l, idx;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_due = 0;
        end else begin
            ev = (exp_q.size() > 0);
            eb = ev || done_due;
            ed = ev ? exp_q[0] : 16'h0;
            check("out_vld", out_vld, ev);
            check("busy", busy, eb);
            check("done", done, done_due);
            check("out_data", out_data, ed);
`ifdef SER_PARITY_EN
            check("out_par", out_par, ^ed);
`endif
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            done_due = 0;
            if (ev && out_rdy) begin
                acc_w.push_back(out_data);
                acc_c.push_back(cyc);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) done_due = 1;
            end
            if (ld && !eb) begin
                ld_cyc = cyc;
                l = ((len_words == 0) || (len_words > NW)) ? NW : int'(len_words);
                for (int k = 0; k < l; k++) begin
                    idx = msw_first ? (l - 1 - k) : k;
                    exp_q.push_back(data_in[idx*16 +: 16]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] d, input logic [2:0] len, input logic m);
        data_in = d;
        len_words = len;
        msw_first = m;
        ld = 1'b1;
        step();
        ld = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base;
        base = done_cnt;
        for (int k = 0; k < 60; k++) begin
            if (done_cnt > base) break;
            step();
        end
        check(name, done_cnt > base, 1);
    endtask

    task automatic clr();
        acc_w.delete();
        acc_c.delete();
    endtask

    task automatic check_words(input string name, input logic [63:0] w4, input int n);
        logic [63:0] t;
        t = w4;
        check({name, "_count"}, acc_w.size(), n);
        for (int k = 0; k < n; k++) check({name, "_word"}, acc_w[k], t[k*16 +: 16]);
    endtask

    localparam logic [63:0] OPA = 64'h4444_3333_2222_1111;
    localparam logic [63:0] OPB = 64'hdddd_cccc_bbbb_aaaa;

    initial begin
        int base, prev_done, n, ldc, dcw;

        step();
        check("rst_out_vld", out_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        step();

        // Full-length LSW-first stream, out_rdy held high
        clr();
        start(OPA, 3'd0, 1'b0);
        wait_done("t1_done_seen");
        check_words("t1", 64'h4444_3333_2222_1111, 4);
        check("t1_first_latency", acc_c[0] - ld_cyc, 1);
        check("t1_done_latency", done_cyc - ld_cyc, 5);

        // MSW-first, two words only
        clr();
        start(OPA, 3'd2, 1'b1);
        wait_done("t2_done_seen");
        check_words("t2", 64'h0000_0000_1111_2222, 2);
        check("t2_done_latency", done_cyc - ld_cyc, 3);

        // Over-long length clamps to the whole operand
        clr();
        start(OPA, 3'd7, 1'b1);
        wait_done("t2b_done_seen");
        check_words("t2b", 64'h1111_2222_3333_4444, 4);

        // Backpressure pattern 1,0,0,1,0,0,...
        clr();
        base = done_cnt;
        start(OPA, 3'd0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (done_cnt > base) break;
            out_rdy = (k % 3 == 0);
            step();
        end
        out_rdy = 1'b1;
        check("t3_done_seen", done_cnt > base, 1);
        check_words("t3", 64'h4444_3333_2222_1111, 4);

        // ld while busy ignored; ld right after done accepted
        clr();
        start(OPA, 3'd0, 1'b0);
        step();
        data_in = OPB;
        ld = 1'b1;
        step();
        data_in = 64'h9999_8888_7777_6666;
        step();
        ld = 1'b0;
        wait_done("t4_done_seen");
        check_words("t4", 64'h4444_3333_2222_1111, 4);
        prev_done = done_cyc;
        clr();
        start(OPB, 3'd0, 1'b0);
        check("t4_ld_after_done", ld_cyc - prev_done, 1);
        wait_done("t4b_done_seen");
        check("t4b_first_latency", acc_c[0] - ld_cyc, 1);
        check_words("t4b", OPB, 4);

        // Asynchronous reset mid-stream
        clr();
        base = done_cnt;
        start(OPA, 3'd0, 1'b0);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_out_vld", out_vld, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_out_data", out_data, 0);
        step();
        rst = 1'b0;
        step();
        check("t5_no_done", done_cnt, base);
        check("t5_beats_before_rst", acc_w.size(), 2);
        clr();
        start(OPB, 3'd0, 1'b0);
        wait_done("t5b_done_seen");
        check_words("t5b", OPB, 4);

        // Wide instance: 512/32, eight LSW-first words of one-hot data
        for (int i = 0; i < 16; i++) data_w[i*32 +: 32] = 32'h1 << i;
        len_w = 5'd8;
        msw_w = 1'b0;
        ld_w = 1'b1;
        ldc = cyc;
        step();
        ld_w = 1'b0;
        n = 0;
        dcw = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_vld_w) begin
                check("tw_word", out_data_w, 32'h1 << n);
`ifdef SER_PARITY_EN
                check("tw_par", out_par_w, 1);
`endif
                n++;
            end
            if (done_w) begin
                dcw = cyc;
                break;
            end
        end
        check("tw_count", n, 8);
        check("tw_done_latency", dcw - ldc, 9);
        step();
        check("tw_idle_busy", busy_w, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
